// File: rtl/bus_sequencer_if.sv
// rtl/bus_sequencer_if.sv - request-channel and RAM-bus signal bundle for bus_sequencer
// master = sequencer side, slave = request sources / bus muxing side.
interface bus_sequencer_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);
  logic [NUM_CH-1:0]        ch_pending_i;
  logic [NUM_CH-1:0]        ch_rw_b_i;
  logic [NUM_CH*ADDR_W-1:0] ch_addr_i;
  logic [NUM_CH*DATA_W-1:0] ch_wr_data_i;
  logic [NUM_CH*DATA_W-1:0] ch_rd_data_o;
  logic [NUM_CH-1:0]        ch_done_o;
  logic [DATA_W-1:0]        bus_data_i;
  logic                     phi2_o;
  logic                     cpu_enable_o;
  logic                     video_select_o;
  logic                     video_strobe_o;
  logic [2:0]               video_slot_o;
  logic [NUM_CH-1:0]        ch_grant_o;
  logic [ADDR_W-1:0]        bus_addr_o;
  logic [DATA_W-1:0]        bus_wr_data_o;
  logic                     bus_rw_b_o;
  logic                     mem_oe_o;
  logic                     mem_we_o;

  modport master (
    input  ch_pending_i, ch_rw_b_i, ch_addr_i, ch_wr_data_i, bus_data_i,
    output ch_rd_data_o, ch_done_o, phi2_o, cpu_enable_o, video_select_o,
           video_strobe_o, video_slot_o, ch_grant_o, bus_addr_o, bus_wr_data_o,
           bus_rw_b_o, mem_oe_o, mem_we_o
  );

  modport slave (
    output ch_pending_i, ch_rw_b_i, ch_addr_i, ch_wr_data_i, bus_data_i,
    input  ch_rd_data_o, ch_done_o, phi2_o, cpu_enable_o, video_select_o,
           video_strobe_o, video_slot_o, ch_grant_o, bus_addr_o, bus_wr_data_o,
           bus_rw_b_o, mem_oe_o, mem_we_o
  );
endinterface

// File: rtl/bus_sequencer.sv
// rtl/bus_sequencer.sv - time-slotted CPU/video/channel RAM bus sequencer
// Optional: BUS_SEQ_FIXED_PRIORITY_EN selects lowest-index-wins arbitration instead of round-robin.
module bus_sequencer #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 8,
  parameter int CYCLE_LEN   = 16,
  parameter int SLOT_LEN    = 2,
  parameter int VIDEO_SLOTS = 2
) (
  input  logic            clk,
  input  logic            reset,
  bus_sequencer_if.master bus
);
  localparam int CNT_W = $clog2(CYCLE_LEN);
  localparam int HALF  = CYCLE_LEN / 2;
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACTIVE,
    ST_DONE
  } ch_state_t;

  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         cnt_d;
  ch_state_t                state_q [NUM_CH];
  ch_state_t                state_d [NUM_CH];
  logic [NUM_CH-1:0]        abort_q;
  logic [NUM_CH-1:0]        abort_d;
`ifndef BUS_SEQ_FIXED_PRIORITY_EN
  logic [PTR_W-1:0]         rr_ptr_q;
  logic [PTR_W-1:0]         rr_ptr_d;
  int                       cand;
`endif

  // Slot decode for the current and the upcoming cnt value.
  int                       nxt_slot;
  logic                     cur_last;
  logic                     nxt_first;
  logic                     nxt_last;
  logic                     nxt_low;
  logic                     nxt_video;
  logic                     arb_slot;

  logic [NUM_CH-1:0]        eligible;
  logic                     win_valid;
  logic [PTR_W-1:0]         win_idx;
  logic                     grant;

  logic                     act_any_d;
  logic [PTR_W-1:0]         act_idx_d;
  logic [NUM_CH-1:0]        grant_d;
  logic [NUM_CH-1:0]        done_d;
  logic [ADDR_W-1:0]        addr_d;
  logic [DATA_W-1:0]        wr_data_d;
  logic                     rw_b_d;
  logic                     we_d;
  logic                     oe_d;
  logic                     phi2_d;
  logic                     strobe_d;
  logic [2:0]               vslot_d;

  logic                     phi2_q;
  logic                     video_select_q;
  logic                     video_strobe_q;
  logic [2:0]               video_slot_q;
  logic [NUM_CH-1:0]        grant_q;
  logic [NUM_CH-1:0]        done_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [DATA_W-1:0]        wr_data_q;
  logic                     rw_b_q;
  logic                     oe_q;
  logic                     we_q;
  logic [NUM_CH*DATA_W-1:0] rd_data_q;

  always_comb begin
    cnt_d     = (cnt_q == CNT_W'(CYCLE_LEN - 1)) ? '0 : cnt_q + 1'b1;
    cur_last  = ((int'(cnt_q) % SLOT_LEN) == SLOT_LEN - 1);
    nxt_first = ((int'(cnt_d) % SLOT_LEN) == 0);
    nxt_last  = ((int'(cnt_d) % SLOT_LEN) == SLOT_LEN - 1);
    nxt_low   = (int'(cnt_d) < HALF);
    nxt_slot  = int'(cnt_d) / SLOT_LEN;
    nxt_video = nxt_low && (nxt_slot < VIDEO_SLOTS);
    arb_slot  = nxt_low && !nxt_video && nxt_first;
  end

  // Arbitration is decided on the edge that enters a channel slot.
  always_comb begin
    eligible  = '0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      eligible[k] = (state_q[k] == ST_WAIT) && bus.ch_pending_i[k];
    end
`ifdef BUS_SEQ_FIXED_PRIORITY_EN
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        win_valid = 1'b1;
        win_idx   = PTR_W'(k);
      end
    end
`else
    cand = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = (int'(rr_ptr_q) + k) % NUM_CH;
      if (eligible[cand]) begin
        win_valid = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
`endif
  end

  assign grant = arb_slot && win_valid;

  always_comb begin
    abort_d = abort_q;
`ifndef BUS_SEQ_FIXED_PRIORITY_EN
    rr_ptr_d = grant ? PTR_W'((int'(win_idx) + 1) % NUM_CH) : rr_ptr_q;
`endif
    for (int k = 0; k < NUM_CH; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        ST_IDLE: begin
          if (bus.ch_pending_i[k]) state_d[k] = ST_WAIT;
        end
        ST_WAIT: begin
          if (!bus.ch_pending_i[k]) begin
            state_d[k] = ST_IDLE;
          end else if (grant && (int'(win_idx) == k)) begin
            state_d[k] = ST_ACTIVE;
            abort_d[k] = 1'b0;
          end
        end
        ST_ACTIVE: begin
          // A withdrawn request still finishes its slot but never reports done.
          if (!bus.ch_pending_i[k]) abort_d[k] = 1'b1;
          if (cur_last) begin
            state_d[k] = (bus.ch_pending_i[k] && !abort_q[k]) ? ST_DONE : ST_IDLE;
          end
        end
        ST_DONE: begin
          if (!bus.ch_pending_i[k]) state_d[k] = ST_IDLE;
        end
        default: state_d[k] = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from next-cycle values so they line up with cnt.
  always_comb begin
    act_any_d = 1'b0;
    act_idx_d = '0;
    grant_d   = '0;
    done_d    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (state_d[k] == ST_ACTIVE) begin
        act_any_d  = 1'b1;
        act_idx_d  = PTR_W'(k);
        grant_d[k] = 1'b1;
      end
      done_d[k] = (state_d[k] == ST_DONE);
    end
    addr_d    = act_any_d ? bus.ch_addr_i[int'(act_idx_d)*ADDR_W +: ADDR_W] : '0;
    wr_data_d = act_any_d ? bus.ch_wr_data_i[int'(act_idx_d)*DATA_W +: DATA_W] : '0;
    rw_b_d    = act_any_d ? bus.ch_rw_b_i[act_idx_d] : 1'b1;
    we_d      = act_any_d && !rw_b_d && !nxt_first;
    oe_d      = nxt_video || (act_any_d && rw_b_d);
    phi2_d    = (int'(cnt_d) >= HALF);
    strobe_d  = nxt_video && nxt_last;
    vslot_d   = nxt_video ? 3'(nxt_slot) : 3'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= '0;
      abort_q        <= '0;
`ifndef BUS_SEQ_FIXED_PRIORITY_EN
      rr_ptr_q       <= '0;
`endif
      for (int k = 0; k < NUM_CH; k++) state_q[k] <= ST_IDLE;
      phi2_q         <= 1'b0;
      video_select_q <= 1'b0;
      video_strobe_q <= 1'b0;
      video_slot_q   <= 3'd0;
      grant_q        <= '0;
      done_q         <= '0;
      addr_q         <= '0;
      wr_data_q      <= '0;
      rw_b_q         <= 1'b1;
      oe_q           <= 1'b0;
      we_q           <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      cnt_q          <= cnt_d;
      abort_q        <= abort_d;
`ifndef BUS_SEQ_FIXED_PRIORITY_EN
      rr_ptr_q       <= rr_ptr_d;
`endif
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= state_d[k];
        if ((state_q[k] == ST_ACTIVE) && rw_b_q && cur_last) begin
          rd_data_q[k*DATA_W +: DATA_W] <= bus.bus_data_i;
        end
      end
      phi2_q         <= phi2_d;
      video_select_q <= nxt_video;
      video_strobe_q <= strobe_d;
      video_slot_q   <= vslot_d;
      grant_q        <= grant_d;
      done_q         <= done_d;
      addr_q         <= addr_d;
      wr_data_q      <= wr_data_d;
      rw_b_q         <= rw_b_d;
      oe_q           <= oe_d;
      we_q           <= we_d;
    end
  end

  assign bus.phi2_o         = phi2_q;
  assign bus.cpu_enable_o   = phi2_q;
  assign bus.video_select_o = video_select_q;
  assign bus.video_strobe_o = video_strobe_q;
  assign bus.video_slot_o   = video_slot_q;
  assign bus.ch_grant_o     = grant_q;
  assign bus.ch_done_o      = done_q;
  assign bus.bus_addr_o     = addr_q;
  assign bus.bus_wr_data_o  = wr_data_q;
  assign bus.bus_rw_b_o     = rw_b_q;
  assign bus.mem_oe_o       = oe_q;
  assign bus.mem_we_o       = we_q;
  assign bus.ch_rd_data_o   = rd_data_q;
endmodule

// File: tb/tb_bus_sequencer.sv
// tb/tb_bus_sequencer.sv - scoreboard bench for bus_sequencer
`timescale 1ns/1ps
module tb_bus_sequencer;
  localparam int NUM_CH = 2, ADDR_W = 17, DATA_W = 8;
  localparam int CYCLE_LEN = 16, SLOT_LEN = 2, VIDEO_SLOTS = 2;
  localparam int HALF = CYCLE_LEN / 2;
  localparam int VID_END = VIDEO_SLOTS * SLOT_LEN;

  logic clk = 1'b0;
  logic reset = 1'b1;

  bus_sequencer_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  bus_sequencer #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .CYCLE_LEN(CYCLE_LEN), .SLOT_LEN(SLOT_LEN), .VIDEO_SLOTS(VIDEO_SLOTS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                ch;
    bit                rw_b;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cnt;
  } access_t;

  access_t exp_q[$];
  access_t cur;
  bit      cur_valid = 0;
  int      cur_cyc = 0;
  int      n_cmp = 0;
  int      n_err = 0;
  int      mcnt = 0;
  bit      settled = 0;
  bit      mon_en = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cnt %0d)", tag, obs, exp, mcnt);
    end
  endtask

  // Reference cycle counter; settled is low for the first cycle after reset.
  always @(posedge clk) begin
    mcnt    <= reset ? 0 : ((mcnt == CYCLE_LEN - 1) ? 0 : mcnt + 1);
    settled <= !reset;
  end

  always @(negedge clk) begin
    if (mon_en && settled) begin
      check_value("phi2", bif.phi2_o, mcnt >= HALF);
      check_value("cpu_en", bif.cpu_enable_o, mcnt >= HALF);
      check_value("vid_sel", bif.video_select_o, mcnt < VID_END);
      check_value("vid_strobe", bif.video_strobe_o, (mcnt < VID_END) && (mcnt % SLOT_LEN == SLOT_LEN - 1));
      check_value("vid_slot", bif.video_slot_o, (mcnt < VID_END) ? mcnt / SLOT_LEN : 0);
      if (!cur_valid && bif.ch_grant_o != '0) begin
        if (exp_q.size() == 0) begin
          check_value("grant_unexpected", bif.ch_grant_o, 0);
        end else begin
          cur       = exp_q.pop_front();
          cur_valid = 1;
          cur_cyc   = 0;
          check_value("grant_cnt", mcnt, cur.cnt);
        end
      end
      if (cur_valid) begin
        check_value("grant", bif.ch_grant_o, 1 << cur.ch);
        check_value("addr", bif.bus_addr_o, cur.addr);
        check_value("wr_data", bif.bus_wr_data_o, cur.data);
        check_value("rw_b", bif.bus_rw_b_o, cur.rw_b);
        check_value("we", bif.mem_we_o, !cur.rw_b && (cur_cyc != 0));
        check_value("oe", bif.mem_oe_o, cur.rw_b || (mcnt < VID_END));
        cur_cyc++;
        if (cur_cyc == SLOT_LEN) cur_valid = 0;
      end else begin
        check_value("idle_grant", bif.ch_grant_o, 0);
        check_value("idle_we", bif.mem_we_o, 0);
        check_value("idle_rw_b", bif.bus_rw_b_o, 1);
        check_value("idle_addr", bif.bus_addr_o, 0);
        check_value("idle_oe", bif.mem_oe_o, mcnt < VID_END);
      end
    end else begin
      cur_valid = 0;
    end
  end

  task automatic wait_cnt(input int v);
    for (int i = 0; i < 2 * CYCLE_LEN; i++) begin
      @(negedge clk);
      if (mcnt == v) break;
    end
  endtask

  task automatic request(input int ch, input bit rw_b, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data, input int gcnt);
    access_t a;
    bif.ch_addr_i[ch*ADDR_W +: ADDR_W]    = addr;
    bif.ch_wr_data_i[ch*DATA_W +: DATA_W] = data;
    bif.ch_rw_b_i[ch]                     = rw_b;
    bif.ch_pending_i[ch]                  = 1'b1;
    a.ch = ch; a.rw_b = rw_b; a.addr = addr; a.data = data; a.cnt = gcnt;
    exp_q.push_back(a);
  endtask

  task automatic wait_done(input int ch, input int exp_cnt, input string tag);
    bit seen = 0;
    for (int i = 0; i < (NUM_CH + 2) * CYCLE_LEN; i++) begin
      @(negedge clk);
      if (bif.ch_done_o[ch]) begin
        seen = 1;
        break;
      end
    end
    check_value({tag, "_done_seen"}, seen, 1);
    if (seen) check_value({tag, "_done_cnt"}, mcnt, exp_cnt);
  endtask

  task automatic release_ch(input int ch, input string tag);
    bif.ch_pending_i[ch] = 1'b0;
    @(negedge clk);
    check_value({tag, "_done_drop"}, bif.ch_done_o[ch], 0);
  endtask

  task automatic check_reset_state(input string tag);
    check_value({tag, "_phi2"}, bif.phi2_o, 0);
    check_value({tag, "_cpu_en"}, bif.cpu_enable_o, 0);
    check_value({tag, "_vid_sel"}, bif.video_select_o, 0);
    check_value({tag, "_vid_strobe"}, bif.video_strobe_o, 0);
    check_value({tag, "_vid_slot"}, bif.video_slot_o, 0);
    check_value({tag, "_grant"}, bif.ch_grant_o, 0);
    check_value({tag, "_done"}, bif.ch_done_o, 0);
    check_value({tag, "_oe"}, bif.mem_oe_o, 0);
    check_value({tag, "_we"}, bif.mem_we_o, 0);
    check_value({tag, "_rw_b"}, bif.bus_rw_b_o, 1);
    check_value({tag, "_addr"}, bif.bus_addr_o, 0);
    check_value({tag, "_wr_data"}, bif.bus_wr_data_o, 0);
    check_value({tag, "_rd_data"}, bif.ch_rd_data_o, 0);
  endtask

  initial begin
    bif.ch_pending_i = '0;
    bif.ch_rw_b_i    = '1;
    bif.ch_addr_i    = '0;
    bif.ch_wr_data_i = '0;
    bif.bus_data_i   = '0;
    reset            = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset  = 1'b0;
    mon_en = 1;

    // Free-running with no requests.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check_value("noreq_done", bif.ch_done_o, 0);
    end

    // Channel 0 write.
    wait_cnt(0);
    request(0, 1'b0, 17'h1E80E, 8'hA5, 4);
    wait_done(0, 6, "wr0");
    release_ch(0, "wr0");

    // Channel 1 read.
    bif.bus_data_i = 8'h3C;
    wait_cnt(0);
    request(1, 1'b1, 17'h08000, 8'h00, 4);
    wait_done(1, 6, "rd1");
    check_value("rd1_data", bif.ch_rd_data_o[15:8], 8'h3C);
    check_value("rd1_ch0_data", bif.ch_rd_data_o[7:0], 8'h00);
    release_ch(1, "rd1");

    // Both pending with rr_ptr at 0: ch0 in slot 2, ch1 in slot 3.
    for (int r = 0; r < 2; r++) begin
      bif.bus_data_i = (r == 0) ? 8'h5A : 8'hC3;
      wait_cnt(0);
      request(0, 1'b0, ADDR_W'(17'h00123 + r), DATA_W'(8'h11 + r), 4);
      request(1, 1'b1, 17'h1FFFF, 8'h00, 6);
      wait_done(0, 6, "both0");
      wait_done(1, 8, "both1");
      check_value("both_rd", bif.ch_rd_data_o[15:8], (r == 0) ? 8'h5A : 8'hC3);
      release_ch(0, "both0");
      release_ch(1, "both1");
    end

    // Request withdrawn mid-slot: access completes, no done, then re-grantable.
    wait_cnt(0);
    request(0, 1'b0, 17'h0AAAA, 8'h77, 4);
    wait_cnt(4);
    bif.ch_pending_i[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_value("abort_no_done", bif.ch_done_o[0], 0);
    end
    wait_cnt(0);
    request(0, 1'b0, 17'h05555, 8'h88, 4);
    wait_done(0, 6, "regrant0");
    release_ch(0, "regrant0");
    check_value("rd_hold", bif.ch_rd_data_o[15:8], 8'hC3);

    // Last grant went to ch0, so round-robin now favours ch1.
    bif.bus_data_i = 8'h96;
    wait_cnt(0);
`ifdef BUS_SEQ_FIXED_PRIORITY_EN
    request(0, 1'b0, 17'h10001, 8'h42, 4);
    request(1, 1'b1, 17'h00FF0, 8'h00, 6);
    wait_done(0, 6, "pri0");
    wait_done(1, 8, "pri1");
`else
    request(1, 1'b1, 17'h00FF0, 8'h00, 4);
    request(0, 1'b0, 17'h10001, 8'h42, 6);
    wait_done(1, 6, "rr1");
    wait_done(0, 8, "rr0");
`endif
    check_value("prio_rd", bif.ch_rd_data_o[15:8], 8'h96);
    release_ch(0, "prio0");
    release_ch(1, "prio1");

    // Reset in the middle of a write.
    wait_cnt(0);
    request(0, 1'b0, 17'h1E80E, 8'h5C, 4);
    wait_cnt(5);
    check_value("rst_pre_we", bif.mem_we_o, 1);
    reset  = 1'b1;
    mon_en = 0;
    bif.ch_pending_i = '0;
    @(negedge clk);
    check_reset_state("midrst");
    reset  = 1'b0;
    mon_en = 1;

    // Sequencer recovers from cnt 0 with all channels idle.
    wait_cnt(0);
    request(1, 1'b0, 17'h00001, 8'h3E, 4);
    wait_done(1, 6, "post_rst");
    release_ch(1, "post_rst");

    repeat (4) @(negedge clk);
    check_value("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bus_sequencer.md
Name: bus_sequencer

Overview:
- Parametrised, time-slotted RAM/bus sequencer that generalises the current fixed three-way sharing (CPU, video, Pi) of the 17-bit system bus.
- Divides each 1 MHz CPU cycle into clk-rate slots:
  - CPU owns the phi2-high half.
  - Video owns the first VIDEO_SLOTS slots of the phi2-low half.
  - The remaining low-half slots serve NUM_CH pending/done request channels (Pi SPI bridge, future DMA), chosen round-robin.
- Sits between the request sources and the top-level bus muxing and RAM strobes.

Parameters:
- NUM_CH, 2, number of request channels (1..8).
- ADDR_W, 17, bus address width.
- DATA_W, 8, bus data width.
- CYCLE_LEN, 16, clk cycles per phi2 period (even, ≥8).
- SLOT_LEN, 2, clk cycles per low-half slot. (CYCLE_LEN/2) must be divisible by SLOT_LEN.
- VIDEO_SLOTS, 2, low-half slots reserved for video. Must be < (CYCLE_LEN/2)/SLOT_LEN.

Ports:
- clk  in  1  16 MHz master clock
- reset  in  1  synchronous, active-high reset
- ch_pending_i  in  NUM_CH  per-channel request level; already in clk domain
- ch_rw_b_i  in  NUM_CH  per-channel direction; 1 = read, 0 = write
- ch_addr_i  in  NUM_CH*ADDR_W  packed per-channel addresses; channel n at [n*ADDR_W +: ADDR_W]
- ch_wr_data_i  in  NUM_CH*DATA_W  packed per-channel write data
- ch_rd_data_o  out  NUM_CH*DATA_W  per-channel captured read data
- ch_done_o  out  NUM_CH  per-channel completion level
- bus_data_i  in  DATA_W  bus data sampled on reads
- phi2_o  out  1  CPU clock
- cpu_enable_o  out  1  CPU owns the bus
- video_select_o  out  1  video slot active
- video_strobe_o  out  1  one-clk pulse on the last cycle of each video slot
- video_slot_o  out  3  index of the current video slot
- ch_grant_o  out  NUM_CH  one-hot channel owning the current slot
- bus_addr_o  out  ADDR_W  granted channel address; 0 otherwise
- bus_wr_data_o  out  DATA_W  granted channel write data
- bus_rw_b_o  out  1  bus direction; 1 unless a channel is writing
- mem_oe_o  out  1  RAM output enable
- mem_we_o  out  1  RAM write enable

Behaviour:
- Cycle counter
  - Counter `cnt` runs 0..CYCLE_LEN-1 and wraps.
  - phi2_o = (cnt ≥ CYCLE_LEN/2), registered.
  - cpu_enable_o equals phi2_o.
- Low half
  - Slot index = cnt / SLOT_LEN.
  - Slots 0..VIDEO_SLOTS-1 are video: video_select_o = 1, mem_oe_o = 1, video_slot_o = slot index, video_strobe_o = 1 on the slot's last cycle.
  - Remaining slots are channel slots.
- Arbitration
  - Evaluated on the first cycle of each channel slot.
  - Eligible channels are in state WAIT.
  - Round-robin starts at rr_ptr. After a grant, rr_ptr = granted+1 mod NUM_CH.
  - No eligible channel: the slot idles, with all strobes 0 and ch_grant_o = 0.
- Per-channel FSM
  - IDLE → WAIT when pending = 1.
  - WAIT → ACTIVE when granted.
  - ACTIVE lasts SLOT_LEN cycles:
    - bus_addr_o, bus_rw_b_o and bus_wr_data_o are driven for the whole slot.
    - Read: mem_oe_o = 1 for the whole slot; bus_data_i is captured into ch_rd_data_o on the last cycle.
    - Write: mem_we_o = 1 on all cycles except the first (address setup).
  - ACTIVE → DONE after the slot. ch_done_o = 1 from the cycle after the slot ends.
  - DONE → IDLE when pending = 0. ch_done_o drops the next cycle (four-phase handshake).
- Boundary cases
  - Pending deasserts while in WAIT: → IDLE, no access.
  - Pending deasserts while in ACTIVE: the slot completes, ch_done_o stays 0, → IDLE.
  - Pending stays high while in DONE: the channel holds DONE and is not re-granted until pending drops and rises again.
  - ch_rd_data_o holds its value until that channel's next read.
  - Latency from pending in IDLE to ch_done_o: at most NUM_CH × CYCLE_LEN + CYCLE_LEN clks.
- Reset
  - Takes effect on the next clk edge, including mid-slot.
  - cnt = 0 and rr_ptr = 0; all FSMs IDLE.
  - phi2_o, cpu_enable_o, video_select_o, video_strobe_o, ch_grant_o, ch_done_o, mem_oe_o and mem_we_o = 0.
  - bus_rw_b_o = 1; bus_addr_o, bus_wr_data_o, ch_rd_data_o and video_slot_o = 0.
  - A write in flight is truncated; mem_we_o is 0 the cycle after reset is sampled.

Optional Feature:
- BUS_SEQ_FIXED_PRIORITY_EN
  - Defined: arbitration is fixed priority, with the lowest channel index winning; rr_ptr is removed.
  - Undefined: round-robin as above.

Test Plan:
- Reset, then run 32 clks with no requests → phi2_o toggles every 8 clks; video_strobe_o pulses at cnt = 1 and 3; ch_grant_o, mem_we_o and ch_done_o stay 0.
- Channel 0 write: addr 0x1E80E, data 0xA5 → granted in slot 2 (cnt 4–5); mem_we_o = 1 only at cnt = 5; bus_rw_b_o = 0; ch_done_o[0] = 1 at cnt = 6; drop pending → done = 0 one clk later.
- Channel 1 read of addr 0x08000 with bus_data_i = 0x3C during the slot → ch_rd_data_o[15:8] = 0x3C; done handshake completes.
- Both channels pending continuously with rr_ptr = 0 → grants alternate ch0 (slot 2), ch1 (slot 3); repeat handshakes alternate; with BUS_SEQ_FIXED_PRIORITY_EN, ch0 is granted first in every cycle in which both are pending.
- Pending drops during an ACTIVE slot → access completes, ch_done_o stays 0, channel is re-grantable after re-assertion.
- Reset asserted at cnt = 5 during a write → next cycle mem_we_o = 0, cnt = 0, all FSMs IDLE, bus_rw_b_o = 1.
